// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one single-port, fixed-latency memory between the instruction
// fetch port and the data port. Data has priority, bounded by an anti-starvation streak limit.
module mem_arbiter #(
   parameter int P_DATA_WIDTH  = 32,
   parameter int P_ADDR_WIDTH  = 10,
   parameter int P_MEM_LATENCY = 1,
   parameter int P_MAX_DSTREAK = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_i_req,
   input  logic [P_ADDR_WIDTH-1:0] i_i_addr,
   output logic                    o_i_ack,
   output logic [P_DATA_WIDTH-1:0] o_i_rdata,
   input  logic                    i_d_req,
   input  logic                    i_d_we,
   input  logic [P_ADDR_WIDTH-1:0] i_d_addr,
   input  logic [P_DATA_WIDTH-1:0] i_d_wdata,
   output logic                    o_d_ack,
   output logic [P_DATA_WIDTH-1:0] o_d_rdata,
   output logic                    o_stall_i,
   output logic                    o_stall_d,
   output logic                    o_mem_en,
   output logic                    o_mem_we,
   output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
   output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

   localparam int C_LAT_W  = $clog2(P_MEM_LATENCY + 1);
   localparam int C_STRK_W = $clog2(P_MAX_DSTREAK + 1);

   localparam logic [C_LAT_W-1:0]  C_LAT_LOAD = C_LAT_W'(P_MEM_LATENCY);
   localparam logic [C_LAT_W-1:0]  C_LAT_ONE  = C_LAT_W'(1);
   localparam logic [C_STRK_W-1:0] C_STRK_MAX = C_STRK_W'(P_MAX_DSTREAK);
   localparam logic [C_STRK_W-1:0] C_STRK_ONE = C_STRK_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_grant_d;
   logic                  r_we;
   logic [C_LAT_W-1:0]    r_lat_cnt;
   logic [C_STRK_W-1:0]   r_streak;
   logic [C_STRK_W-1:0]   w_streak_nxt;
   logic                  w_issue;
   logic                  w_grant_d;
   logic                  w_capture;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_streak_nxt = r_streak;
      w_issue      = 1'b0;
      w_grant_d    = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_i_req || i_d_req) begin
               w_state_nxt = S_ISSUE;
               w_issue     = 1'b1;
               w_grant_d   = i_d_req && (!i_i_req || (r_streak < C_STRK_MAX));
               // Streak only counts data wins over a waiting fetch; the limit check
               // above keeps it from ever exceeding the maximum.
               if (!w_grant_d) begin
                  w_streak_nxt = '0;
               end else if (i_i_req) begin
                  w_streak_nxt = r_streak + C_STRK_ONE;
               end
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_lat_cnt == C_LAT_ONE) begin
               w_state_nxt = S_ACK;
               w_capture   = 1'b1;
            end
         end
         S_ACK: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant_d   <= 1'b0;
         r_we        <= 1'b0;
         r_lat_cnt   <= '0;
         r_streak    <= '0;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_i_ack     <= 1'b0;
         o_d_ack     <= 1'b0;
         o_i_rdata   <= '0;
         o_d_rdata   <= '0;
      end else begin
         r_streak <= w_streak_nxt;
         // Memory strobes are launched from the IDLE decision so they are
         // registered and coincide exactly with the ISSUE state.
         o_mem_en <= w_issue;
         o_mem_we <= w_issue & w_grant_d & i_d_we;
         if (w_issue) begin
            r_grant_d <= w_grant_d;
            r_we      <= w_grant_d & i_d_we;
            if (w_grant_d) begin
               o_mem_addr  <= i_d_addr;
               o_mem_wdata <= i_d_wdata;
            end else begin
               o_mem_addr  <= i_i_addr;
            end
         end

         if (r_state == S_ISSUE) begin
            r_lat_cnt <= C_LAT_LOAD;
         end else if (r_state == S_WAIT) begin
            r_lat_cnt <= r_lat_cnt - C_LAT_ONE;
         end

         o_i_ack <= w_capture & ~r_grant_d;
         o_d_ack <= w_capture &  r_grant_d;

         if (w_capture && !r_we) begin
            if (r_grant_d) begin
               o_d_rdata <= i_mem_rdata;
            end else begin
               o_i_rdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_stall_i = i_i_req & ~o_i_ack;
   assign o_stall_d = i_d_req & ~o_d_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_mem_arbiter: directed checks of arbitration, latency, starvation limit and reset
// on a latency-1 instance (streak limit 2) and a latency-3 instance.
module tb_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          i_ack, d_ack, stall_i, stall_d, mem_en, mem_we;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic          i_req3, d_req3, d_we3;
   logic [AW-1:0] i_addr3, d_addr3;
   logic [DW-1:0] d_wdata3;
   logic          i_ack3, d_ack3, stall_i3, stall_d3, mem_en3, mem_we3;
   logic [DW-1:0] i_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
   logic [AW-1:0] mem_addr3;

   mem_arbiter #(
      .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_MEM_LATENCY(1), .P_MAX_DSTREAK(2)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_i_req(i_req), .i_i_addr(i_addr), .o_i_ack(i_ack), .o_i_rdata(i_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_ack(d_ack), .o_d_rdata(d_rdata),
      .o_stall_i(stall_i), .o_stall_d(stall_d),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   mem_arbiter #(
      .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_MEM_LATENCY(3), .P_MAX_DSTREAK(4)
   ) dut3 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_i_req(i_req3), .i_i_addr(i_addr3), .o_i_ack(i_ack3), .o_i_rdata(i_rdata3),
      .i_d_req(d_req3), .i_d_we(d_we3), .i_d_addr(d_addr3), .i_d_wdata(d_wdata3),
      .o_d_ack(d_ack3), .o_d_rdata(d_rdata3),
      .o_stall_i(stall_i3), .o_stall_d(stall_d3),
      .o_mem_en(mem_en3), .o_mem_we(mem_we3), .o_mem_addr(mem_addr3),
      .o_mem_wdata(mem_wdata3), .i_mem_rdata(mem_rdata3)
   );

   // Memory contents: 0x010 holds an ADDI instruction, everything else a tagged address.
   function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
      if (a == 10'h010) return 32'h0050_0093;
      return {22'h0, a} ^ 32'h5A5A_0000;
   endfunction

   // Latency-1 macro with one write slot; read data is zero except in the valid cycle.
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr  = '0;
   logic [DW-1:0] wr_data  = '0;
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         wr_valid <= 1'b1;
         wr_addr  <= mem_addr;
         wr_data  <= mem_wdata;
      end
      if (mem_en && !mem_we)
         mem_rdata <= (wr_valid && wr_addr == mem_addr) ? wr_data : pattern(mem_addr);
      else
         mem_rdata <= '0;
   end

   // Latency-3 read-only macro.
   logic [DW-1:0] p0 = '0, p1 = '0, p2 = '0;
   always @(posedge clk) begin
      p0 <= (mem_en3 && !mem_we3) ? pattern(mem_addr3) : '0;
      p1 <= p0;
      p2 <= p1;
   end
   assign mem_rdata3 = p2;

   task automatic drain();
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; i_req3 = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      i_req3 = 1'b0; i_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_en, mem_we, i_ack, d_ack, stall_i, stall_d} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected %b",
                  {mem_en, mem_we, i_ack, d_ack, stall_i, stall_d}, 6'b0);
      end
      checks++;
      if ({mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
      end
      checks++;
      if ({i_rdata, d_rdata, i_rdata3, d_rdata3} !== '0) begin
         errors++;
         $display("FAIL reset_rdata: got %h %h %h %h expected 0", i_rdata, d_rdata, i_rdata3, d_rdata3);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_en, i_ack, d_ack, mem_en3, i_ack3} !== 5'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b expected %b", {mem_en, i_ack, d_ack, mem_en3, i_ack3}, 5'b0);
      end
   endtask

   task automatic test_instr_read();
      logic [5:0]    en_v, ack_v, stall_v;
      logic [AW-1:0] addr_c1;
      logic          we_c1;
      en_v = '0; ack_v = '0; stall_v = '0; addr_c1 = '0; we_c1 = 1'b1;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 10'h010;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         en_v[c] = mem_en; ack_v[c] = i_ack; stall_v[c] = stall_i;
         if (c == 1) begin addr_c1 = mem_addr; we_c1 = mem_we; end
         if (i_ack) i_req = 1'b0;
      end
      i_req = 1'b0;
      checks++;
      if (en_v !== 6'b000010) begin errors++; $display("FAIL instr_mem_en: got %b expected %b", en_v, 6'b000010); end
      checks++;
      if (ack_v !== 6'b001000) begin errors++; $display("FAIL instr_ack: got %b expected %b", ack_v, 6'b001000); end
      checks++;
      if (stall_v !== 6'b000111) begin errors++; $display("FAIL instr_stall: got %b expected %b", stall_v, 6'b000111); end
      checks++;
      if (addr_c1 !== 10'h010 || we_c1 !== 1'b0) begin
         errors++; $display("FAIL instr_issue_bus: got addr %h we %b expected 010 0", addr_c1, we_c1);
      end
      checks++;
      if (i_rdata !== 32'h0050_0093) begin errors++; $display("FAIL instr_rdata: got %h expected %h", i_rdata, 32'h0050_0093); end
      drain();
   endtask

   task automatic test_write_read();
      logic [5:0]    we_v, ack_v;
      logic [AW-1:0] addr_c1;
      logic [DW-1:0] wdata_c1;
      we_v = '0; ack_v = '0; addr_c1 = '0; wdata_c1 = '0;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3F0; d_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         we_v[c] = mem_we; ack_v[c] = d_ack;
         if (c == 1) begin addr_c1 = mem_addr; wdata_c1 = mem_wdata; end
         if (d_ack) d_req = 1'b0;
      end
      d_req = 1'b0;
      checks++;
      if (we_v !== 6'b000010) begin errors++; $display("FAIL write_we: got %b expected %b", we_v, 6'b000010); end
      checks++;
      if (ack_v !== 6'b001000) begin errors++; $display("FAIL write_ack: got %b expected %b", ack_v, 6'b001000); end
      checks++;
      if (addr_c1 !== 10'h3F0 || wdata_c1 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_bus: got addr %h wdata %h expected 3f0 deadbeef", addr_c1, wdata_c1);
      end
      checks++;
      if (d_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata_hold: got %h expected %h", d_rdata, 32'h0); end
      drain();
      ack_v = '0;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'h3F0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         ack_v[c] = d_ack;
         if (d_ack) d_req = 1'b0;
      end
      d_req = 1'b0;
      checks++;
      if (ack_v !== 6'b001000) begin errors++; $display("FAIL read_ack: got %b expected %b", ack_v, 6'b001000); end
      checks++;
      if (d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata: got %h expected %h", d_rdata, 32'hDEAD_BEEF); end
      checks++;
      if (i_rdata !== 32'h0050_0093) begin errors++; $display("FAIL irdata_hold: got %h expected %h", i_rdata, 32'h0050_0093); end
      drain();
   endtask

   task automatic test_simultaneous();
      logic [9:0]    en_v, iack_v, dack_v;
      logic [AW-1:0] addr_c1, addr_c5;
      en_v = '0; iack_v = '0; dack_v = '0; addr_c1 = '0; addr_c5 = '0;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 10'h020;
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         en_v[c] = mem_en; iack_v[c] = i_ack; dack_v[c] = d_ack;
         if (c == 1) addr_c1 = mem_addr;
         if (c == 5) addr_c5 = mem_addr;
         if (i_ack) i_req = 1'b0;
         if (d_ack) d_req = 1'b0;
      end
      checks++;
      if (en_v !== 10'b0000100010) begin errors++; $display("FAIL simul_mem_en: got %b expected %b", en_v, 10'b0000100010); end
      checks++;
      if (dack_v !== 10'b0000001000) begin errors++; $display("FAIL simul_dack: got %b expected %b", dack_v, 10'b0000001000); end
      checks++;
      if (iack_v !== 10'b0010000000) begin errors++; $display("FAIL simul_iack: got %b expected %b", iack_v, 10'b0010000000); end
      checks++;
      if (addr_c1 !== 10'h100 || addr_c5 !== 10'h020) begin
         errors++; $display("FAIL simul_order: got addrs %h %h expected 100 020", addr_c1, addr_c5);
      end
      checks++;
      if (d_rdata !== 32'h5A5A_0100 || i_rdata !== 32'h5A5A_0020) begin
         errors++; $display("FAIL simul_rdata: got d %h i %h expected 5a5a0100 5a5a0020", d_rdata, i_rdata);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [9:0] en_v, ack_v;
      int         nack;
      en_v = '0; ack_v = '0; nack = 0;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 10'h030;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         en_v[c] = mem_en; ack_v[c] = i_ack;
         if (i_ack) begin
            nack++;
            if (nack == 2) i_req = 1'b0;
         end
      end
      i_req = 1'b0;
      checks++;
      if (en_v !== 10'b0000100010) begin errors++; $display("FAIL held_mem_en: got %b expected %b", en_v, 10'b0000100010); end
      checks++;
      if (ack_v !== 10'b0010001000) begin errors++; $display("FAIL held_ack: got %b expected %b", ack_v, 10'b0010001000); end
      checks++;
      if (i_rdata !== 32'h5A5A_0030) begin errors++; $display("FAIL held_rdata: got %h expected %h", i_rdata, 32'h5A5A_0030); end
      drain();
   endtask

   task automatic test_starvation();
      logic [5:0] seq;
      int         n, last_cyc, en_cnt;
      logic       both;
      seq = '0; n = 0; last_cyc = -1; en_cnt = 0; both = 1'b0;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 10'h050;
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'h060;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         if (mem_en) en_cnt++;
         if (i_ack && d_ack) both = 1'b1;
         if (i_ack || d_ack) begin
            seq[n] = d_ack;
            n++;
            last_cyc = c;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      checks++;
      if (seq !== 6'b011011 || n != 6) begin
         errors++; $display("FAIL starve_order: got %b (%0d grants) expected %b (6 grants)", seq, n, 6'b011011);
      end
      checks++;
      if (last_cyc != 23) begin errors++; $display("FAIL starve_timing: got %0d expected %0d", last_cyc, 23); end
      checks++;
      if (en_cnt != 6 || both !== 1'b0) begin
         errors++; $display("FAIL starve_strobes: got %0d en, both=%b expected 6 en, both=0", en_cnt, both);
      end
      drain();
   endtask

   task automatic test_reset_mid_wait();
      logic [7:0] en_v, ack_v;
      logic       stray;
      en_v = '0; ack_v = '0; stray = 1'b0;
      @(posedge clk); #1;
      i_req3 = 1'b1; i_addr3 = 10'h010;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         en_v[c] = mem_en3; ack_v[c] = i_ack3;
         if (i_ack3) i_req3 = 1'b0;
      end
      i_req3 = 1'b0;
      checks++;
      if (en_v !== 8'b00000010 || ack_v !== 8'b00100000) begin
         errors++; $display("FAIL lat3_timing: got en %b ack %b expected 00000010 00100000", en_v, ack_v);
      end
      checks++;
      if (i_rdata3 !== 32'h0050_0093) begin errors++; $display("FAIL lat3_rdata: got %h expected %h", i_rdata3, 32'h0050_0093); end
      drain();
      @(posedge clk); #1;
      i_req3 = 1'b1; i_addr3 = 10'h044;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0; i_req3 = 1'b0;
      #1;
      checks++;
      if ({mem_en3, mem_we3, i_ack3, d_ack3, stall_i3} !== 5'b0 || mem_addr3 !== '0 || i_rdata3 !== '0) begin
         errors++;
         $display("FAIL reset_async: got ctrl %b addr %h rdata %h expected 0",
                  {mem_en3, mem_we3, i_ack3, d_ack3, stall_i3}, mem_addr3, i_rdata3);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (i_ack3 || d_ack3) stray = 1'b1;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (i_ack3 || d_ack3 || mem_en3) stray = 1'b1;
      end
      checks++;
      if (stray !== 1'b0) begin errors++; $display("FAIL reset_no_ack: got %b expected %b", stray, 1'b0); end
      ack_v = '0;
      @(posedge clk); #1;
      i_req3 = 1'b1; i_addr3 = 10'h044;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         ack_v[c] = i_ack3;
         if (i_ack3) i_req3 = 1'b0;
      end
      i_req3 = 1'b0;
      checks++;
      if (ack_v !== 8'b00100000) begin errors++; $display("FAIL post_reset_ack: got %b expected %b", ack_v, 8'b00100000); end
      checks++;
      if (i_rdata3 !== 32'h5A5A_0044) begin errors++; $display("FAIL post_reset_rdata: got %h expected %h", i_rdata3, 32'h5A5A_0044); end
      drain();
   endtask

   initial begin
      test_reset();
      test_instr_read();
      test_write_read();
      test_simultaneous();
      test_back_to_back();
      test_starvation();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
